// File: rtl/rx_temporal_cb_if.sv
// AXI-Stream bundle carrying LANES parallel streams; the merger takes RATIO lanes
// on its slave side and drives a single lane on its master side.
interface rx_temporal_cb_if #(
  parameter int DWIDTH = 128,
  parameter int LANES  = 1
);
  logic [LANES-1:0][DWIDTH-1:0]   tdata;
  logic [LANES-1:0][DWIDTH/8-1:0] tkeep;
  logic [LANES-1:0]               tlast;
  logic [LANES-1:0]               tvalid;
  logic [LANES-1:0]               tready;

  modport master (
    output tdata, tkeep, tlast, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tlast, tvalid,
    output tready
  );
endinterface

// File: rtl/rx_temporal_cb.sv
// Temporal channel-bonding merger: RATIO slow lanes, each buffered in a small FIFO,
// re-serialized strictly round-robin (lane 0 first) onto one fast AXI-Stream.
module rx_temporal_cb #(
  parameter int DWIDTH     = 128,
  parameter int RATIO      = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(RATIO)-1:0] clk_cnt,
  rx_temporal_cb_if.slave          s_axis,
  rx_temporal_cb_if.master         m_axis
);
  localparam int KW   = DWIDTH / 8;
  localparam int EW   = DWIDTH + KW + 1;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;
  localparam int PHW  = $clog2(RATIO);
  localparam logic [PHW-1:0]  PHASE_LAST = PHW'(RATIO - 1);
  localparam logic [CNTW-1:0] DEPTH_C    = CNTW'(FIFO_DEPTH);

  logic [RATIO-1:0]         sel_q, sel_d;
  logic [RATIO-1:0]         lane_nonempty;
  logic [RATIO-1:0][EW-1:0] lane_head;
  logic [EW-1:0]            m_entry;
  logic                     m_valid;
  logic                     m_fire;

  assign m_fire = m_valid & m_axis.tready[0];

  for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
    logic [EW-1:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            ready_q, ready_d;
    logic            push, pop;

    // One sample per slow period, taken on its last fast cycle.
    assign push = (clk_cnt == PHASE_LAST) && s_axis.tvalid[gi] && ready_q;
    assign pop  = m_fire && sel_q[gi];

    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ready_d  = ready_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      // Ready only changes at a period start, so it is flat across the slow period.
      if (clk_cnt == '0) ready_d = (count_q < DEPTH_C);
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        ready_q  <= 1'b0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
        ready_q  <= ready_d;
      end
    end

    always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {s_axis.tlast[gi], s_axis.tkeep[gi], s_axis.tdata[gi]};
    end

    assign lane_head[gi]     = mem_q[rd_ptr_q];
    assign lane_nonempty[gi] = (count_q != '0);
    assign s_axis.tready[gi] = ready_q;
  end

  always_comb begin
    m_entry = '0;
    m_valid = 1'b0;
    for (int i = 0; i < RATIO; i++) begin
      if (sel_q[i]) begin
        m_entry = m_entry | lane_head[i];
        m_valid = m_valid | lane_nonempty[i];
      end
    end
  end

  // Strict order: the pointer only moves on a handshake, never skips an empty lane.
  always_comb begin
    sel_d = sel_q;
    if (m_fire) sel_d = {sel_q[RATIO-2:0], sel_q[RATIO-1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) sel_q <= RATIO'(1);
    else        sel_q <= sel_d;
  end

  assign m_axis.tdata[0]  = m_entry[DWIDTH-1:0];
  assign m_axis.tkeep[0]  = m_entry[DWIDTH +: KW];
  assign m_axis.tlast[0]  = m_entry[EW-1];
  assign m_axis.tvalid[0] = m_valid;
endmodule
